// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 16-bit combinational ALU: registers a command onto the ALU inputs,
// waits SETTLE_CYCLES, then captures result/flags behind a valid/ready handshake.
module alu_cmd_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opc,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic             cmd_c,
    input  logic             cmd_use_acc,
    output logic [2:0]       alu_opc,
    output logic [15:0]      alu_ina,
    output logic [15:0]      alu_inb,
    output logic             alu_inc,
    input  logic [15:0]      alu_w,
    input  logic             alu_zer,
    input  logic             alu_neg,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_w,
    output logic             res_zer,
    output logic             res_neg,
    output logic             res_err,
    output logic [15:0]      acc,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    localparam logic [2:0] OPC_UNDEF   = 3'b111;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] settle_cnt;

    // Handshake outputs are registered next to the state so they change only on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            cmd_ready  <= 1'b1;
            res_valid  <= 1'b0;
            alu_opc    <= '0;
            alu_ina    <= '0;
            alu_inb    <= '0;
            alu_inc    <= 1'b0;
            res_w      <= '0;
            res_zer    <= 1'b0;
            res_neg    <= 1'b0;
            res_err    <= 1'b0;
            acc        <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_opc   <= cmd_opc;
                        alu_ina   <= cmd_use_acc ? acc : cmd_a;
                        alu_inb   <= cmd_b;
                        alu_inc   <= cmd_c;
                        cmd_ready <= 1'b0;
                        if (cmd_opc == OPC_UNDEF) begin
                            res_w     <= '0;
                            res_zer   <= 1'b0;
                            res_neg   <= 1'b0;
                            res_err   <= 1'b1;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            settle_cnt <= SETTLE_LOAD;
                            state      <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        res_w     <= alu_w;
                        res_zer   <= alu_zer;
                        res_neg   <= alu_neg;
                        res_err   <= 1'b0;
                        acc       <= alu_w;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        op_count  <= op_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    cmd_ready <= 1'b1;
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: one instance with SETTLE_CYCLES=1, one with SETTLE_CYCLES=4
// and a 2-bit counter, each wired to a behavioural ALU.
module tb_alu_cmd_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst         [2];
    logic        cmd_valid   [2];
    logic        cmd_ready   [2];
    logic [2:0]  cmd_opc     [2];
    logic [15:0] cmd_a       [2];
    logic [15:0] cmd_b       [2];
    logic        cmd_c       [2];
    logic        cmd_use_acc [2];
    logic [2:0]  alu_opc     [2];
    logic [15:0] alu_ina     [2];
    logic [15:0] alu_inb     [2];
    logic        alu_inc     [2];
    logic [15:0] alu_w       [2];
    logic        alu_zer     [2];
    logic        alu_neg     [2];
    logic        res_valid   [2];
    logic        res_ready   [2];
    logic [15:0] res_w       [2];
    logic        res_zer     [2];
    logic        res_neg     [2];
    logic        res_err     [2];
    logic [15:0] acc         [2];
    logic [7:0]  op_count1;
    logic [1:0]  op_count4;

    int total  = 0;
    int passed = 0;

    // Reference ALU; opcode 111 returns a marker so a leaked capture would be visible.
    function automatic logic [15:0] aluModel(input logic [2:0] opc, input logic [15:0] a,
                                             input logic [15:0] b, input logic c);
        case (opc)
            3'b000:  return ~a + 16'd1;
            3'b001:  return a + b + {15'd0, c};
            3'b010:  return a - b - {15'd0, c};
            3'b011:  return a & b;
            3'b100:  return a | b;
            3'b101:  return a ^ b;
            3'b110:  return {a[7:0], b[7:0]};
            default: return 16'hDEAD;
        endcase
    endfunction

    assign alu_w[0]   = aluModel(alu_opc[0], alu_ina[0], alu_inb[0], alu_inc[0]);
    assign alu_zer[0] = (alu_w[0] == 16'h0000);
    assign alu_neg[0] = alu_w[0][15];
    assign alu_w[1]   = aluModel(alu_opc[1], alu_ina[1], alu_inb[1], alu_inc[1]);
    assign alu_zer[1] = (alu_w[1] == 16'h0000);
    assign alu_neg[1] = alu_w[1][15];

    alu_cmd_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst[0]),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_opc(cmd_opc[0]),
        .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_c(cmd_c[0]), .cmd_use_acc(cmd_use_acc[0]),
        .alu_opc(alu_opc[0]), .alu_ina(alu_ina[0]), .alu_inb(alu_inb[0]), .alu_inc(alu_inc[0]),
        .alu_w(alu_w[0]), .alu_zer(alu_zer[0]), .alu_neg(alu_neg[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_w(res_w[0]),
        .res_zer(res_zer[0]), .res_neg(res_neg[0]), .res_err(res_err[0]),
        .acc(acc[0]), .op_count(op_count1)
    );

    alu_cmd_sequencer #(.SETTLE_CYCLES(4), .CNT_W(2)) dut4 (
        .clk(clk), .rst(rst[1]),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_opc(cmd_opc[1]),
        .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_c(cmd_c[1]), .cmd_use_acc(cmd_use_acc[1]),
        .alu_opc(alu_opc[1]), .alu_ina(alu_ina[1]), .alu_inb(alu_inb[1]), .alu_inc(alu_inc[1]),
        .alu_w(alu_w[1]), .alu_zer(alu_zer[1]), .alu_neg(alu_neg[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_w(res_w[1]),
        .res_zer(res_zer[1]), .res_neg(res_neg[1]), .res_err(res_err[1]),
        .acc(acc[1]), .op_count(op_count4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        else
            passed++;
    endtask

    // Presents a command at a falling edge and returns on the falling edge after it was accepted.
    task automatic applyStimulus(input int d, input logic [2:0] opc, input logic [15:0] a,
                                 input logic [15:0] b, input logic c, input logic useAcc);
        int n = 0;
        cmd_valid[d]   = 1'b1;
        cmd_opc[d]     = opc;
        cmd_a[d]       = a;
        cmd_b[d]       = b;
        cmd_c[d]       = c;
        cmd_use_acc[d] = useAcc;
        while (!cmd_ready[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) checkOutput("accept timeout", 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid[d] = 1'b0;
    endtask

    task automatic waitResult(input int d, input int expLat, input string tag);
        int lat = 1;
        while (!res_valid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " latency"}, lat, expLat);
    endtask

    task automatic consumeResult(input int d);
        res_ready[d] = 1'b1;
        @(negedge clk);
        res_ready[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; cmd_valid[k] = 1'b0; cmd_opc[k] = '0; cmd_a[k] = '0;
            cmd_b[k] = '0; cmd_c[k] = 1'b0; cmd_use_acc[k] = 1'b0; res_ready[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        checkOutput("reset cmd_ready", cmd_ready[0], 1);
        checkOutput("reset res_valid", res_valid[0], 0);
        checkOutput("reset acc", acc[0], 0);
        checkOutput("reset op_count", op_count1, 0);
        checkOutput("reset res_w", res_w[0], 0);
        checkOutput("reset alu_ina", alu_ina[0], 0);
        checkOutput("reset s4 cmd_ready", cmd_ready[1], 1);
        checkOutput("reset s4 res_valid", res_valid[1], 0);

        // Negate 1 -> FFFF
        applyStimulus(0, 3'b000, 16'h0001, 16'h0000, 1'b0, 1'b0);
        checkOutput("neg alu_ina", alu_ina[0], 16'h0001);
        waitResult(0, 2, "neg");
        checkOutput("neg res_w", res_w[0], 16'hFFFF);
        checkOutput("neg res_neg", res_neg[0], 1);
        checkOutput("neg res_zer", res_zer[0], 0);
        checkOutput("neg res_err", res_err[0], 0);
        checkOutput("neg acc", acc[0], 16'hFFFF);
        consumeResult(0);
        checkOutput("neg res_valid drop", res_valid[0], 0);
        checkOutput("neg op_count", op_count1, 1);

        // Chain: 7FFF+1 = 8000, then acc - 8000 = 0
        applyStimulus(0, 3'b001, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        waitResult(0, 2, "add");
        checkOutput("add res_w", res_w[0], 16'h8000);
        checkOutput("add acc", acc[0], 16'h8000);
        consumeResult(0);
        applyStimulus(0, 3'b010, 16'h1234, 16'h8000, 1'b0, 1'b1);
        checkOutput("chain alu_ina", alu_ina[0], 16'h8000);
        waitResult(0, 2, "chain");
        checkOutput("chain res_w", res_w[0], 16'h0000);
        checkOutput("chain res_zer", res_zer[0], 1);
        checkOutput("chain res_neg", res_neg[0], 0);
        checkOutput("chain acc", acc[0], 16'h0000);
        consumeResult(0);
        checkOutput("chain op_count", op_count1, 3);

        // Byte concat held for 5 cycles with a pending command waiting
        applyStimulus(0, 3'b110, 16'h12AB, 16'h34CD, 1'b0, 1'b0);
        waitResult(0, 2, "cat");
        cmd_valid[0] = 1'b1; cmd_opc[0] = 3'b011; cmd_a[0] = 16'hFF00;
        cmd_b[0] = 16'h0F0F; cmd_c[0] = 1'b0; cmd_use_acc[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold res_valid", res_valid[0], 1);
            checkOutput("hold res_w", res_w[0], 16'hABCD);
            checkOutput("hold res_neg", res_neg[0], 1);
            checkOutput("hold cmd_ready", cmd_ready[0], 0);
            checkOutput("hold alu_opc", alu_opc[0], 3'b110);
            @(negedge clk);
        end
        consumeResult(0);
        checkOutput("cat res_valid drop", res_valid[0], 0);
        checkOutput("cat cmd_ready", cmd_ready[0], 1);
        checkOutput("cat alu_opc kept", alu_opc[0], 3'b110);
        checkOutput("cat op_count", op_count1, 4);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        checkOutput("pending accepted", cmd_ready[0], 0);
        checkOutput("pending alu_opc", alu_opc[0], 3'b011);
        checkOutput("pending alu_ina", alu_ina[0], 16'hFF00);
        waitResult(0, 2, "and");
        checkOutput("and res_w", res_w[0], 16'h0F00);
        checkOutput("and acc", acc[0], 16'h0F00);
        consumeResult(0);

        // Undefined opcode with acc = 5
        applyStimulus(0, 3'b001, 16'h0004, 16'h0001, 1'b0, 1'b0);
        waitResult(0, 2, "add5");
        checkOutput("add5 acc", acc[0], 16'h0005);
        consumeResult(0);
        applyStimulus(0, 3'b111, 16'h9999, 16'h1111, 1'b1, 1'b0);
        waitResult(0, 1, "undef");
        checkOutput("undef res_err", res_err[0], 1);
        checkOutput("undef res_w", res_w[0], 16'h0000);
        checkOutput("undef res_zer", res_zer[0], 0);
        checkOutput("undef res_neg", res_neg[0], 0);
        checkOutput("undef acc", acc[0], 16'h0005);
        consumeResult(0);
        checkOutput("undef op_count", op_count1, 7);
        res_ready[0] = 1'b1;
        repeat (2) @(negedge clk);
        res_ready[0] = 1'b0;
        checkOutput("idle res_ready op_count", op_count1, 7);
        checkOutput("idle res_ready res_valid", res_valid[0], 0);
        applyStimulus(0, 3'b101, 16'h0000, 16'h0FF0, 1'b0, 1'b1);
        waitResult(0, 2, "xor");
        checkOutput("xor res_err", res_err[0], 0);
        checkOutput("xor res_w", res_w[0], 16'h0FF5);
        consumeResult(0);

        // SETTLE_CYCLES = 4 instance
        applyStimulus(1, 3'b100, 16'h00F0, 16'h0F00, 1'b0, 1'b0);
        waitResult(1, 5, "s4 or");
        checkOutput("s4 or res_w", res_w[1], 16'h0FF0);
        checkOutput("s4 or acc", acc[1], 16'h0FF0);
        consumeResult(1);
        checkOutput("s4 op_count", op_count4, 1);

        // Reset during the second settle cycle
        applyStimulus(1, 3'b000, 16'h0003, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        checkOutput("midrst cmd_ready", cmd_ready[1], 1);
        checkOutput("midrst res_valid", res_valid[1], 0);
        checkOutput("midrst acc", acc[1], 0);
        checkOutput("midrst op_count", op_count4, 0);
        checkOutput("midrst alu_ina", alu_ina[1], 0);
        repeat (6) @(negedge clk);
        checkOutput("midrst no result", res_valid[1], 0);
        applyStimulus(1, 3'b000, 16'h0003, 16'h0000, 1'b0, 1'b0);
        waitResult(1, 5, "s4 neg");
        checkOutput("s4 neg res_w", res_w[1], 16'hFFFD);
        checkOutput("s4 neg res_neg", res_neg[1], 1);
        checkOutput("s4 neg acc", acc[1], 16'hFFFD);
        consumeResult(1);

        // Error results counted; 2-bit counter wraps 3 -> 0
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 3'b111, 16'h0000, 16'h0000, 1'b0, 1'b0);
            waitResult(1, 1, "s4 err");
            consumeResult(1);
        end
        checkOutput("s4 wrap op_count", op_count4, 0);
        checkOutput("s4 wrap acc", acc[1], 16'hFFFD);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side for the team's combinational 16-bit ALU (opcode, operand A/B, carry-in in; result, zero and negative flags out).
- Accepts operation commands over a valid/ready handshake and drives the ALU inputs from registered values.
- Waits a programmable settle time, then captures result and flags into an output register presented over a second valid/ready handshake.
- Keeps an accumulator, so a command can use the previous result as operand A for chained operations.

Parameters:
- SETTLE_CYCLES, 1, cycles the ALU inputs are held before capture (legal range 1..15).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_opc  input  3  ALU opcode
- cmd_a  input  16  operand A
- cmd_b  input  16  operand B
- cmd_c  input  1  carry-in
- cmd_use_acc  input  1  1 = operand A taken from the accumulator, cmd_a ignored
- alu_opc  output  3  to ALU opcode
- alu_ina  output  16  to ALU operand A
- alu_inb  output  16  to ALU operand B
- alu_inc  output  1  to ALU carry-in
- alu_w  input  16  ALU result
- alu_zer  input  1  ALU zero flag
- alu_neg  input  1  ALU negative flag
- res_valid  output  1  result register holds an unconsumed result
- res_ready  input  1  consumer accepts the result
- res_w  output  16  captured result
- res_zer  output  1  captured zero flag
- res_neg  output  1  captured negative flag
- res_err  output  1  command used undefined opcode 3'b111
- acc  output  16  accumulator (last non-error result)
- op_count  output  CNT_W  number of results consumed; wraps modulo 2^CNT_W

Behaviour:
- Reset: all outputs, registers and the accumulator go to 0. State goes to IDLE, and cmd_ready = 1 in the cycle after rst deasserts. Reset mid-operation abandons the command with no result.
- States are IDLE, SETTLE, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register opc, A (acc when cmd_use_acc = 1), B and C onto the alu_* outputs.
  - If opc = 3'b111, go straight to DONE with res_w = 0, res_zer = 0, res_neg = 0, res_err = 1. No settle wait; acc is unchanged.
  - Otherwise load the settle counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE:
  - alu_* outputs stay stable; cmd_ready = 0.
  - When the counter is 0, capture alu_w, alu_zer and alu_neg into res_*, set res_err = 0 and acc = alu_w, then go to DONE.
  - Latency from command accept to res_valid = SETTLE_CYCLES+1 cycles.
- DONE:
  - res_valid = 1; res_* stay stable until consumed; cmd_ready = 0.
  - On res_ready, res_valid drops next cycle, op_count increments, and the state returns to IDLE.
- Back-to-back: no command overlap. The next command is accepted no earlier than the cycle after the result handshake. cmd_valid held during SETTLE/DONE is ignored, not lost; it is accepted on return to IDLE.
- alu_* outputs hold their last values in IDLE until a new command is accepted; they are never glitched mid-operation.
- res_ready asserted while res_valid = 0 has no effect.
- op_count wraps 2^CNT_W-1 -> 0 silently. Error results are counted.
- Flags are taken from the ALU, not recomputed. The sequencer performs no arithmetic apart from the counters.

Test Plan:
- Reset then idle: rst high 2 cycles -> res_valid = 0, acc = 0, op_count = 0, cmd_ready = 1 on the first cycle after release.
- Two's-complement negate: opc = 000, a = 16'h0001, SETTLE_CYCLES = 1 -> res_valid on cycle 2 after accept, res_w = 16'hFFFF, res_neg = 1, res_zer = 0, acc = 16'hFFFF.
- Accumulator chaining: opc = 001, a = 16'h7FFF, then opc = 010, use_acc = 1, c = 0 -> second result res_w = 16'h0000, res_zer = 1, res_neg = 0; op_count = 2.
- Byte concatenation with held result: opc = 110, a = 16'h12AB, b = 16'h34CD, res_ready held low 5 cycles -> res_w = 16'hABCD, res_neg = 1 stable throughout; cmd_ready = 0 and a pending cmd_valid is not accepted until after the handshake.
- Undefined opcode: opc = 111 with acc = 16'h0005 -> res_err = 1, res_w = 0, acc stays 16'h0005, latency 1 cycle, op_count increments.
- Reset mid-SETTLE with SETTLE_CYCLES = 4: rst at settle cycle 2 -> no res_valid, acc = 0, op_count = 0, next command completes normally.
